// File: rtl/ovi_store_sink.sv
// Store-data sink for the vector unit: hands out packet credits to the core,
// buffers the returned store-data packets and signals when a store is complete.
// Optional byte masking is enabled with the OVI_STORE_MASK_EN macro.
module ovi_store_sink #(
   parameter int unsigned DATA_W  = 512,
   parameter int unsigned DEPTH   = 16,   // power of two, at least 2
   parameter int unsigned CREDITS = 4,
   parameter int unsigned VL_W    = 15
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     START,
   input  logic [VL_W-1:0]          VL,
   input  logic [1:0]               SEW,
   input  logic                     STORE_VALID,
   input  logic [DATA_W-1:0]        STORE_DATA,
`ifdef OVI_STORE_MASK_EN
   input  logic [DATA_W/8-1:0]      STORE_MASK,
`endif
   output logic                     STORE_CREDIT,
   output logic                     SYNC_END,
   output logic                     BUSY,
   output logic                     ERR,
   output logic [15:0]              PKT_COUNT,
   input  logic [$clog2(DEPTH)-1:0] RD_ADDR,
   output logic [DATA_W-1:0]        RD_DATA
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StReceive, StDone} state_e;

   state_e      state_q;
   logic [31:0] n_pkts_q;
   logic [31:0] granted_q;
   logic [15:0] pkt_count_q;
   logic        err_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [31:0] elem_bits;
   logic [31:0] n_calc;
   logic [31:0] outstanding;
   logic        in_rx;
   logic        credit;
   logic        accept;
   logic [15:0] pkt_next;

   // Packet count, credit decision and acceptance from the current registered state
   always_comb begin
      elem_bits   = 32'd8 << SEW;
      n_calc      = (32'(VL) * elem_bits + DATA_W - 1) / DATA_W;
      outstanding = granted_q - {16'b0, pkt_count_q};
      in_rx       = (state_q == StReceive);
      // Outstanding excludes this cycle's grant: a packet needs an earlier credit
      credit      = in_rx && (granted_q < n_pkts_q) && (outstanding < CREDITS);
      accept      = in_rx && STORE_VALID && (outstanding != 32'd0);
      pkt_next    = pkt_count_q + 16'(accept);
   end

   // Control FSM with credit and packet counters
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= StIdle;
         n_pkts_q    <= 32'd0;
         granted_q   <= 32'd0;
         pkt_count_q <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         if (STORE_VALID && !accept) err_q <= 1'b1;
         if (START && state_q != StIdle) err_q <= 1'b1;
         case (state_q)
            StIdle: begin
               if (START) begin
                  n_pkts_q    <= n_calc;
                  granted_q   <= 32'd0;
                  pkt_count_q <= 16'd0;
                  state_q     <= StReceive;
               end
            end
            StReceive: begin
               if (credit) granted_q <= granted_q + 32'd1;
               pkt_count_q <= pkt_next;
               // Also covers N=0, which finishes on the first receive cycle
               if ({16'b0, pkt_next} == n_pkts_q) state_q <= StDone;
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Packet buffer; written at the packet index, wrapping over the oldest entries
   always_ff @(posedge CLK) begin
      if (accept) begin
`ifdef OVI_STORE_MASK_EN
         for (int b = 0; b < int'(DATA_W / 8); b++) begin
            if (STORE_MASK[b]) mem[pkt_count_q[AW-1:0]][b*8 +: 8] <= STORE_DATA[b*8 +: 8];
         end
`else
         mem[pkt_count_q[AW-1:0]] <= STORE_DATA;
`endif
      end
   end

   // Output decode of registered state
   always_comb begin
      STORE_CREDIT = credit;
      SYNC_END     = (state_q == StDone);
      BUSY         = (state_q != StIdle);
      ERR          = err_q;
      PKT_COUNT    = pkt_count_q;
      RD_DATA      = mem[RD_ADDR];
   end

endmodule

// File: tb/tb_ovi_store_sink.sv
// Directed bench for ovi_store_sink with default parameters.
module tb_ovi_store_sink;

   logic         CLK = 1'b0;
   logic         RST_N;
   logic         START;
   logic [14:0]  VL;
   logic [1:0]   SEW;
   logic         STORE_VALID;
   logic [511:0] STORE_DATA;
   logic [63:0]  STORE_MASK;
   logic         STORE_CREDIT;
   logic         SYNC_END;
   logic         BUSY;
   logic         ERR;
   logic [15:0]  PKT_COUNT;
   logic [3:0]   RD_ADDR;
   logic [511:0] RD_DATA;

   int n_checks = 0;
   int n_pass   = 0;

   // results of the last run_store
   int r_credits, r_early, r_syncs, r_sync_cyc, r_last_pkt, r_sent;

   ovi_store_sink dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .START        (START),
      .VL           (VL),
      .SEW          (SEW),
      .STORE_VALID  (STORE_VALID),
      .STORE_DATA   (STORE_DATA),
`ifdef OVI_STORE_MASK_EN
      .STORE_MASK   (STORE_MASK),
`endif
      .STORE_CREDIT (STORE_CREDIT),
      .SYNC_END     (SYNC_END),
      .BUSY         (BUSY),
      .ERR          (ERR),
      .PKT_COUNT    (PKT_COUNT),
      .RD_ADDR      (RD_ADDR),
      .RD_DATA      (RD_DATA)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [511:0] pat(input logic [15:0] seed, input int i);
      logic [15:0] lo;
      lo = i[15:0];
      return {16{seed, lo}};
   endfunction

   task automatic rd_check(input string tag, input int addr, input logic [511:0] exp);
      RD_ADDR = addr[3:0];
      #1;
      check(tag, RD_DATA, exp);
   endtask

   // Issue one store and play the core: every credit seen is answered with one
   // packet in a later cycle, except that nothing is returned during the first
   // `hold` cycles after START.
   task automatic run_store(input int vl, input int sew, input int hold, input int budget,
                            input logic [15:0] seed);
      int owed;
      int cyc;
      owed = 0;
      r_credits = 0; r_early = 0; r_syncs = 0; r_sync_cyc = -1; r_last_pkt = -1; r_sent = 0;
      @(negedge CLK);
      VL = vl[14:0]; SEW = sew[1:0]; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      cyc = 1;
      while (cyc <= budget) begin
         if (owed > 0 && cyc > hold) begin
            STORE_VALID = 1'b1;
            STORE_DATA  = pat(seed, r_sent);
            r_sent++;
            owed--;
            r_last_pkt = cyc;
         end else begin
            STORE_VALID = 1'b0;
         end
         if (STORE_CREDIT) begin
            r_credits++;
            owed++;
         end
         if (cyc <= hold) r_early = r_credits;
         if (SYNC_END) begin
            r_syncs++;
            r_sync_cyc = cyc;
         end
         @(negedge CLK);
         cyc++;
         if (r_syncs > 0 && cyc > r_sync_cyc + 3) break;
      end
      STORE_VALID = 1'b0;
   endtask

   initial begin
      int owed;
      int guard;
      RST_N = 1'b0; START = 1'b0; VL = '0; SEW = '0; STORE_VALID = 1'b0;
      STORE_DATA = '0; STORE_MASK = '1; RD_ADDR = '0;
      #1;
      check("rst_busy", BUSY, 0);
      check("rst_err", ERR, 0);
      check("rst_pkt", PKT_COUNT, 0);
      check("rst_credit", STORE_CREDIT, 0);
      check("rst_sync", SYNC_END, 0);
      @(negedge CLK);
      RST_N = 1'b1;

      // VL=8, SEW=32b -> one packet
      run_store(8, 2, 0, 40, 16'h0029);
      check("n1_credits", r_credits, 1);
      check("n1_syncs", r_syncs, 1);
      check("n1_sync_lat", r_sync_cyc - r_last_pkt, 1);
      check("n1_pkt", PKT_COUNT, 1);
      check("n1_busy", BUSY, 0);

      // VL=64, SEW=64b -> 8 packets, core withholds for 10 cycles
      run_store(64, 3, 10, 80, 16'h0030);
      check("n8_early_credits", r_early, 4);
      check("n8_credits", r_credits, 8);
      check("n8_syncs", r_syncs, 1);
      check("n8_pkt", PKT_COUNT, 8);
      for (int i = 0; i < 8; i++) rd_check($sformatf("n8_buf%0d", i), i, pat(16'h0030, i));
      check("n8_err", ERR, 0);

      // VL=0 -> no credits, SYNC_END in the second cycle after START
      run_store(0, 1, 0, 20, 16'h0031);
      check("n0_credits", r_credits, 0);
      check("n0_sync_cyc", r_sync_cyc, 2);
      check("n0_syncs", r_syncs, 1);
      check("n0_err", ERR, 0);

      // Packet while idle: dropped and flagged
      @(negedge CLK);
      STORE_VALID = 1'b1;
      STORE_DATA  = {64{8'hA5}};
      @(negedge CLK);
      STORE_VALID = 1'b0;
      check("idle_err", ERR, 1);
      check("idle_pkt", PKT_COUNT, 0);
      rd_check("idle_buf0", 0, pat(16'h0030, 0));

      // Reset in the middle of an 8-packet store
      @(negedge CLK);
      VL = 15'd64; SEW = 2'd3; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      owed  = 0;
      guard = 0;
      r_sent = 0;
      while (PKT_COUNT != 16'd3 && guard < 50) begin
         if (owed > 0) begin
            STORE_VALID = 1'b1;
            STORE_DATA  = pat(16'h0034, r_sent);
            r_sent++;
            owed--;
         end else begin
            STORE_VALID = 1'b0;
         end
         if (STORE_CREDIT) owed++;
         @(negedge CLK);
         guard++;
      end
      check("mid_reached3", PKT_COUNT, 3);
      check("mid_busy_before", BUSY, 1);
      STORE_VALID = 1'b0;
      RST_N = 1'b0;
      #1;
      check("mid_busy", BUSY, 0);
      check("mid_pkt", PKT_COUNT, 0);
      check("mid_err", ERR, 0);
      check("mid_credit", STORE_CREDIT, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      run_store(64, 3, 0, 80, 16'h0035);
      check("post_credits", r_credits, 8);
      check("post_syncs", r_syncs, 1);
      check("post_pkt", PKT_COUNT, 8);

      // 32 packets into 16 entries: buffer keeps the newest 16
      run_store(256, 3, 0, 200, 16'h0033);
      check("n32_credits", r_credits, 32);
      check("n32_syncs", r_syncs, 1);
      check("n32_pkt", PKT_COUNT, 32);
      for (int i = 0; i < 16; i++)
         rd_check($sformatf("n32_buf%0d", i), i, pat(16'h0033, 16 + i));
      check("n32_err", ERR, 0);

      // START while not idle is ignored and flagged
      @(negedge CLK);
      VL = 15'd0; SEW = 2'd0; START = 1'b1;
      @(negedge CLK);
      VL = 15'd64; SEW = 2'd3;
      @(negedge CLK);
      START = 1'b0;
      check("restart_sync", SYNC_END, 1);
      check("restart_err", ERR, 1);
      @(negedge CLK);
      check("restart_idle", BUSY, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
